// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode and select encodings shared by the multicycle RV32I controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_DEC} alu_mode_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_C_ADD = 3'b000;
    localparam logic [2:0] ALU_C_SUB = 3'b001;
    localparam logic [2:0] ALU_C_OR  = 3'b010;
    localparam logic [2:0] ALU_C_AND = 3'b011;
    localparam logic [2:0] ALU_C_SLL = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_ONE = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU op, or forces add/sub; also reports funct3 legality
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  alu_mode_t  mode,
    output logic [2:0] alucontrol,
    output logic       funct3_legal
);

    logic [2:0] dec;

    assign dec = funct3 == 3'b000 ? ((op == OP_R && funct7b5) ? ALU_C_SUB : ALU_C_ADD) :
                 funct3 == 3'b001 ? ALU_C_SLL :
                 funct3 == 3'b110 ? ALU_C_OR : ALU_C_AND;

    assign alucontrol   = mode == ALU_DEC ? dec : mode == ALU_SUB ? ALU_C_SUB : ALU_C_ADD;
    assign funct3_legal = funct3 inside {3'b000, 3'b001, 3'b110, 3'b111};

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencer for a shared-memory multicycle RV32I core
// with memory-ready stalls, illegal-instruction trap and a retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic [1:0]       immsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [1:0]       resultsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t    state, next;
    alu_mode_t mode;
    logic      f3_ok, legal, retire;
    logic      pcw, irw, mw, rw;

    alu_decoder u_alu_decoder (
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .mode         (mode),
        .alucontrol   (alucontrol),
        .funct3_legal (f3_ok)
    );

    assign legal = op == OP_LW || op == OP_SW || op == OP_JAL ||
                   ((op == OP_R || op == OP_I) && f3_ok) ||
                   (op == OP_BEQ && funct3 == 3'b000);

    always_comb begin
        next = state;
        case (state)
            S_FETCH:                  next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:                 next = !legal ? S_ILLEGAL :
                                             (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                             op == OP_R ? S_EXECR :
                                             op == OP_I ? S_EXECI :
                                             op == OP_JAL ? S_JAL : S_BEQ;
            S_MEMADR:                 next = op == OP_SW ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:                next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:               next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL:  next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:  next = S_FETCH;
            default:                  next = S_ILLEGAL;
        endcase
    end

    // A stalled store keeps memwrite high but only retires on the ready cycle
    assign retire = state inside {S_MEMWB, S_ALUWB, S_BEQ} || (state == S_MEMWRITE && mem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state   <= next;
            instret <= instret + CNT_W'(retire);
        end
    end

    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        mw        = 1'b0;
        rw        = 1'b0;
        adrsrc    = 1'b0;
        immsrc    = IMM_I;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        resultsrc = RES_ALUOUT;
        mode      = ALU_ADD;
        case (state)
            S_FETCH: begin
                alusrcb   = SRCB_ONE;
                resultsrc = RES_ALU;
                irw       = mem_ready;
                pcw       = mem_ready;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                immsrc  = IMM_B;
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                immsrc  = op == OP_SW ? IMM_S : IMM_I;
            end
            S_MEMREAD:  adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc = RES_RDATA;
                rw        = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc = 1'b1;
                mw     = 1'b1;
            end
            S_EXECR: begin
                alusrca = SRCA_RS1;
                mode    = ALU_DEC;
            end
            S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                mode    = ALU_DEC;
            end
            S_ALUWB:    rw = 1'b1;
            S_JAL: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_ONE;
                pcw     = 1'b1;
            end
            S_BEQ: begin
                alusrca = SRCA_RS1;
                mode    = ALU_SUB;
                pcw     = zero;
            end
            default: ;
        endcase
    end

    // Write enables are held off for as long as reset is low
    assign pcwrite  = pcw & reset;
    assign irwrite  = irw & reset;
    assign memwrite = mw & reset;
    assign regwrite = rw & reset;
    assign illegal  = state == S_ILLEGAL;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams checked cycle by cycle
// against an instruction-level model of the controller.
module tb_multicycle_controller;

    localparam int W = 4;

    localparam int S_RST = 0, S_F = 1, S_D = 2, S_MA = 3, S_MR = 4, S_MWB = 5, S_MW = 6,
                   S_ER = 7, S_EI = 8, S_AWB = 9, S_J = 10, S_B = 11, S_IL = 12;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

    // got vector: pcwrite adrsrc irwrite memwrite regwrite immsrc alusrca alusrcb alucontrol resultsrc illegal
    localparam logic [16:0] M_PCW = 17'h10000, M_ADR = 17'h08000, M_IRW = 17'h04000,
                            M_MW  = 17'h02000, M_RW  = 17'h01000, M_IMM = 17'h00C00,
                            M_A   = 17'h00300, M_B   = 17'h000C0, M_ALU = 17'h00038,
                            M_RES = 17'h00006, M_ILL = 17'h00001;

    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic [2:0] alucontrol;
    logic [W-1:0] instret;

    multicycle_controller #(.CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .resultsrc  (resultsrc),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int zfix = -1;
    logic exp_on = 1'b0;
    logic [16:0] exp_vec = '0;
    logic [W-1:0] cnt = '0;
    logic pin_on = 1'b0, pinc_on = 1'b0;
    string pin_name = "", pinc_name = "";
    logic [16:0] pin_mask = '0, pin_val = '0;
    logic [W-1:0] pin_cnt = '0;
    logic [16:0] got;

    assign got = {pcwrite, adrsrc, irwrite, memwrite, regwrite, immsrc, alusrca, alusrcb,
                  alucontrol, resultsrc, illegal};

    // Expected outputs of one step of an instruction, straight from the step table
    function automatic logic [16:0] model_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic rdy, input logic z);
        logic pcw, adr, irw, mw, rw, ill;
        logic [1:0] imm, a, b, res;
        logic [2:0] alu, dec;
        {pcw, adr, irw, mw, rw, ill} = '0;
        {imm, a, b, res} = '0;
        alu = 3'b000;
        dec = f3 == 3'd0 ? ((o == RT && f7) ? 3'b001 : 3'b000) :
              f3 == 3'd1 ? 3'b101 : f3 == 3'd6 ? 3'b010 : 3'b011;
        case (s)
            S_RST: begin b = 2; res = 2; end
            S_F:   begin b = 2; res = 2; irw = rdy; pcw = rdy; end
            S_D:   begin a = 1; b = 1; imm = 2; end
            S_MA:  begin a = 2; b = 1; imm = o == SW ? 2'd1 : 2'd0; end
            S_MR:  adr = 1;
            S_MWB: begin res = 1; rw = 1; end
            S_MW:  begin adr = 1; mw = 1; end
            S_ER:  begin a = 2; alu = dec; end
            S_EI:  begin a = 2; b = 1; alu = dec; end
            S_AWB: rw = 1;
            S_J:   begin a = 1; b = 2; pcw = 1; end
            S_B:   begin a = 2; alu = 3'b001; pcw = z; end
            S_IL:  ill = 1;
            default: ;
        endcase
        return {pcw, adr, irw, mw, rw, imm, a, b, alu, res, ill};
    endfunction

    function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
        if (o == LW || o == SW || o == JAL) return 1;
        if (o == RT || o == IT) return f3 == 0 || f3 == 1 || f3 == 6 || f3 == 7;
        return o == BEQ && f3 == 0;
    endfunction

    always @(negedge clk) begin
        if (exp_on) begin
            checks = checks + 2;
            if (got !== exp_vec) begin
                errors = errors + 1;
                $display("FAIL outputs @%0t op=%b f3=%b: got %b, expected %b", $time, op, funct3, got, exp_vec);
            end
            if (instret !== cnt) begin
                errors = errors + 1;
                $display("FAIL instret @%0t: got %0d, expected %0d", $time, instret, cnt);
            end
        end
        if (pin_on) begin
            checks = checks + 1;
            if ((got & pin_mask) !== pin_val) begin
                errors = errors + 1;
                $display("FAIL %s @%0t: got %b, expected %b (mask %b)", pin_name, $time, got & pin_mask, pin_val, pin_mask);
            end
        end
        if (pinc_on) begin
            checks = checks + 1;
            if (instret !== pin_cnt) begin
                errors = errors + 1;
                $display("FAIL %s @%0t: got %0d, expected %0d", pinc_name, $time, instret, pin_cnt);
            end
        end
    end

    task automatic pin(input string n, input logic [16:0] m, input logic [16:0] v);
        pin_name = n; pin_mask = m; pin_val = v; pin_on = 1'b1;
    endtask

    task automatic pinc(input string n, input logic [W-1:0] c);
        pinc_name = n; pin_cnt = c; pinc_on = 1'b1;
    endtask

    // One clock of step s; called just after a rising edge
    task automatic cyc(input int s, input logic rdy);
        mem_ready = rdy;
        zero = zfix < 0 ? 1'($urandom) : 1'(zfix);
        exp_vec = model_out(s, op, funct3, funct7b5, rdy, zero);
        exp_on = 1'b1;
        @(posedge clk);
        #1;
        pin_on = 1'b0;
        pinc_on = 1'b0;
        if (s == S_MWB || s == S_AWB || s == S_B || (s == S_MW && rdy)) cnt = cnt + 1'b1;
    endtask

    task automatic mem(input int s, input int k);
        repeat (k) cyc(s, 1'b0);
        cyc(s, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cnt = '0;
        cyc(S_RST, 1'b1);
        cyc(S_RST, 1'b1);
        reset = 1'b1;
    endtask

    task automatic setins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        setins(o, f3, f7);
        mem(S_F, $urandom_range(0, 2));
        cyc(S_D, 1'($urandom));
        if (!legal(o, f3)) begin
            repeat ($urandom_range(2, 6)) cyc(S_IL, 1'($urandom));
            do_reset();
            return;
        end
        if ($urandom_range(0, 29) == 0) begin
            do_reset();
            return;
        end
        case (o)
            LW:  begin cyc(S_MA, 1'($urandom)); mem(S_MR, $urandom_range(0, 2)); cyc(S_MWB, 1'($urandom)); end
            SW:  begin cyc(S_MA, 1'($urandom)); mem(S_MW, $urandom_range(0, 2)); end
            RT:  begin cyc(S_ER, 1'($urandom)); cyc(S_AWB, 1'($urandom)); end
            IT:  begin cyc(S_EI, 1'($urandom)); cyc(S_AWB, 1'($urandom)); end
            JAL: begin cyc(S_J, 1'($urandom)); cyc(S_AWB, 1'($urandom)); end
            default: cyc(S_B, 1'($urandom));
        endcase
    endtask

    initial begin
        logic [2:0] f3s [4];
        logic [2:0] alus [4];
        f3s  = '{3'd0, 3'd6, 3'd7, 3'd1};
        alus = '{3'b000, 3'b010, 3'b011, 3'b101};
        @(posedge clk);
        #1;
        pin("reset enables", M_PCW | M_IRW | M_RW | M_MW | M_ILL, 17'h0);
        pinc("reset instret", 0);
        do_reset();

        setins(RT, 3'd0, 1'b0);
        pin("add fetch", M_PCW | M_IRW, M_PCW | M_IRW);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("add exec", M_ALU | M_A | M_B, 17'h00200);
        cyc(S_ER, 1'b1);
        pin("add wb", M_RW | M_RES, M_RW);
        cyc(S_AWB, 1'b1);
        pinc("add instret", 1);

        setins(RT, 3'd0, 1'b1);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("sub alu", M_ALU, 17'h00008);
        cyc(S_ER, 1'b1);
        cyc(S_AWB, 1'b1);

        for (int i = 0; i < 4; i++) begin
            setins(IT, f3s[i], 1'b0);
            cyc(S_F, 1'b1);
            cyc(S_D, 1'b1);
            pin("imm alu", M_ALU | M_B, (17'(alus[i]) << 3) | 17'h00040);
            cyc(S_EI, 1'b1);
            cyc(S_AWB, 1'b1);
        end

        setins(LW, 3'd2, 1'b0);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        cyc(S_MA, 1'b1);
        pin("lw stall", M_RW | M_ADR, M_ADR);
        mem(S_MR, 2);
        pin("lw wb", M_RW | M_RES, M_RW | 17'h00002);
        cyc(S_MWB, 1'b1);
        pinc("lw instret", 7);

        setins(SW, 3'd2, 1'b0);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("sw immsrc", M_IMM, 17'h00400);
        cyc(S_MA, 1'b1);
        pin("sw stall memwrite", M_MW | M_ADR, M_MW | M_ADR);
        cyc(S_MW, 1'b0);
        pinc("sw stall instret", 7);
        cyc(S_MW, 1'b1);

        setins(BEQ, 3'd0, 1'b0);
        zfix = 1;
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("beq taken", M_PCW | M_ALU, M_PCW | 17'h00008);
        cyc(S_B, 1'b1);
        zfix = 0;
        pin("beq back to fetch", M_IRW, M_IRW);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("beq not taken", M_PCW, 17'h0);
        cyc(S_B, 1'b1);
        zfix = -1;

        setins(JAL, 3'd0, 1'b0);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        pin("jal", M_PCW | M_A | M_B | M_RW, M_PCW | 17'h00100 | 17'h00080);
        cyc(S_J, 1'b1);
        pin("jal wb", M_RW, M_RW);
        cyc(S_AWB, 1'b1);

        setins(7'b0000000, 3'd0, 1'b0);
        pinc("jal instret", 11);
        cyc(S_F, 1'b1);
        cyc(S_D, 1'b1);
        repeat (12) begin
            pin("illegal hold", M_PCW | M_IRW | M_RW | M_MW | M_ILL, M_ILL);
            cyc(S_IL, 1'b1);
        end
        pin("reset clears illegal", M_ILL, 17'h0);
        pinc("reset clears instret", 0);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [6:0] o;
            logic [2:0] f3, good;
            r = $urandom_range(0, 13);
            o = r < 2 ? LW : r < 4 ? SW : r < 6 ? RT : r < 8 ? IT : r < 9 ? JAL :
                r < 11 ? BEQ : r < 12 ? 7'b0000000 : 7'($urandom);
            good = f3s[$urandom_range(0, 3)];
            f3 = $urandom_range(0, 5) == 0 ? 3'($urandom) : (o == BEQ ? 3'd0 : good);
            run(o, f3, 1'($urandom));
        end

        exp_on = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller that turns the single-cycle RV32I datapath into a multicycle core sharing one memory port for instruction fetch and data access. A Moore state machine issues one datapath step per clock and stalls on a memory-ready handshake. It also produces the ALU operation code, flags unsupported instructions, and keeps a retired-instruction counter. It replaces the combinational main decoder; the datapath gains an instruction register, an old-PC register, an ALU-output register and an address mux.

## Interface

Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` — input, 1 — sole clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-low.
- `op` — input, 7 — `instr[6:0]`, taken from the instruction register.
- `funct3` — input, 3 — `instr[14:12]`.
- `funct7b5` — input, 1 — `instr[30]`.
- `zero` — input, 1 — ALU zero flag.
- `mem_ready` — input, 1 — memory has completed the current read or write this cycle.
- `pcwrite` — output, 1 — PC register enable.
- `adrsrc` — output, 1 — memory address select: 0 = PC, 1 = ALU-output register.
- `irwrite` — output, 1 — instruction register and old-PC register enable.
- `memwrite` — output, 1 — data write strobe.
- `regwrite` — output, 1 — register-file write enable.
- `immsrc` — output, 2 — immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alusrca` — output, 2 — ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- `alusrcb` — output, 2 — ALU B select: 00 = rs2, 01 = immext, 10 = constant 1 (PC is word-addressed).
- `alucontrol` — output, 3 — ALU op: 000 = add, 001 = sub, 010 = or, 011 = and, 101 = sll.
- `resultsrc` — output, 2 — result select: 00 = ALU-output register, 01 = read data, 10 = live ALU result.
- `illegal` — output, 1 — unsupported instruction detected (sticky).
- `instret` — output, `CNT_W` — count of retired instructions.

## Operation

State machine. Reset state is FETCH.
- **FETCH**: adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10.
  - irwrite and pcwrite are asserted only while mem_ready=1.
  - Go to DECODE when mem_ready=1; otherwise stay.
- **DECODE**: alusrca=01, alusrcb=01, immsrc=10, add (precomputes the branch target). Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other op → ILLEGAL
  - ALU classes (0110011, 0010011) whose funct3 is not in {000, 001, 110, 111} → ILLEGAL.
  - BEQ with funct3 ≠ 000 → ILLEGAL.
- **MEMADR**: alusrca=10, alusrcb=01, add. immsrc=00 for lw, 01 for sw. Go to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD**: adrsrc=1. Hold until mem_ready, then go to MEMWB.
- **MEMWB**: resultsrc=01, regwrite=1 → FETCH.
- **MEMWRITE**: adrsrc=1, memwrite=1, held until mem_ready → FETCH.
- **EXECR**: alusrca=10, alusrcb=00, ALU decode → ALUWB.
- **EXECI**: alusrca=10, alusrcb=01, immsrc=00, ALU decode → ALUWB.
- **ALUWB**: resultsrc=00, regwrite=1 → FETCH.
- **JAL**: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1 → ALUWB.
- **BEQ**: alusrca=10, alusrcb=00, sub, resultsrc=00, pcwrite=zero → FETCH.
- **ILLEGAL**: all write enables 0; illegal=1. Leaves only on reset.

ALU decode, used in EXECR and EXECI:
- funct3 000 → sub if (op=0110011 and funct7b5=1), else add.
- funct3 001 → sll (101).
- funct3 110 → or.
- funct3 111 → and.

Unlisted select fields are 00 in every state.

instret:
- Increments by 1 on leaving MEMWB, ALUWB or BEQ, and on a MEMWRITE cycle with mem_ready=1.
- JAL counts once, via ALUWB.
- Wraps from 2^CNT_W−1 to 0.

## Timing

- Reset low: state=FETCH immediately, instret=0, illegal=0. pcwrite, irwrite, regwrite and memwrite are forced to 0 while reset is low; all select outputs show the FETCH decode.
- Outputs are combinational from state, plus zero (BEQ) and mem_ready (FETCH, MEMWRITE). No extra register stage.
- Latency with mem_ready always 1, in cycles including fetch:
  - lw 5
  - sw 4
  - R-type and I-type 4
  - beq 3
  - jal 4
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No side effects occur while stalled: memwrite stays high but is not counted.
- Reset asserted mid-instruction abandons it: no writeback, counter cleared.
- zero is sampled only in BEQ, in the same cycle.

## Structure

- Package `riscv_ctrl_pkg` holds:
  - the state enum (12 states, including ILLEGAL);
  - opcode constants;
  - alucontrol codes;
  - alusrca/alusrcb/resultsrc/immsrc select codes.
- One combinational sub-module, `alu_decoder` (op, funct3, funct7b5, a force-add/force-sub control → alucontrol, funct3_legal). It is used by both the EXEC states and the DECODE legality check.

## Test plan

- **add x3,x1,x2 with mem_ready=1**: 4 cycles.
  - FETCH: irwrite=1, pcwrite=1.
  - EXECR: alucontrol=000.
  - ALUWB: regwrite=1, resultsrc=00.
  - instret goes 0→1.
- **sub (funct7b5=1)**: alucontrol=001.
- **addi, ori, andi, slli**: alucontrol = 000, 010, 011, 101 respectively with alusrcb=01.
- **lw with mem_ready low for 2 cycles in MEMREAD**: 7 cycles total; regwrite pulses once, in MEMWB with resultsrc=01.
- **sw then beq**:
  - sw: memwrite=1 held until mem_ready, immsrc=01.
  - beq with zero=1: pcwrite=1.
  - beq with zero=0: pcwrite=0.
  - Both beq cases return to FETCH after 3 cycles.
- **jal**: JAL cycle has pcwrite=1, alusrca=01, alusrcb=10, followed by ALUWB with regwrite=1; instret +1 only.
- **Illegal op 0000000**: enters ILLEGAL after DECODE; illegal=1 and all enables stay 0 for 10+ cycles. Asserting reset clears illegal and instret and returns to FETCH.
